// File: rtl/huff_bit_packer_if.sv
// Fragment-in / word-out bus of the DEFLATE bit packer.
// The master drives fragments, flush and FIFO status; the slave is the packer.
interface huff_bit_packer_if #(
    parameter int unsigned MAX_CODE_LEN = 25,
    parameter int unsigned LEN_WIDTH    = 5
);
    logic [MAX_CODE_LEN-1:0] code_data;
    logic [LEN_WIDTH-1:0]    code_len;
    logic                    code_valid;
    logic                    code_ready;
    logic                    flush;
    logic                    flush_ack;
    logic                    out_full;
    logic                    out_wren;
    logic [31:0]             out_data;
    logic [2:0]              out_nbytes;
    logic                    out_eof;
    logic [31:0]             word_count;

    modport master (
        output code_data, code_len, code_valid, flush, out_full,
        input  code_ready, flush_ack, out_wren, out_data, out_nbytes, out_eof, word_count
    );

    modport slave (
        input  code_data, code_len, code_valid, flush, out_full,
        output code_ready, flush_ack, out_wren, out_data, out_nbytes, out_eof, word_count
    );
endinterface

// File: rtl/huff_bit_packer.sv
// Packs variable-length code fragments LSB-first into 32-bit words; on flush the
// stream is byte-aligned and a final word carrying a byte count and EOF is written.
module huff_bit_packer #(
    parameter int unsigned MAX_CODE_LEN = 25,
    parameter int unsigned LEN_WIDTH    = 5,
    parameter int unsigned ACC_WIDTH    = 64
) (
    input logic             core_clock,
    input logic             rst_n,
    huff_bit_packer_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(ACC_WIDTH + 1);
    localparam logic [CNT_W-1:0] WORD_BITS = CNT_W'(32);
    localparam logic [CNT_W-1:0] BYTE_PAD  = CNT_W'(7);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_CODE_LEN);

    typedef enum logic [1:0] {StRun, StPad, StDrain, StDone} state_e;

    state_e                state_q, state_d;
    logic [ACC_WIDTH-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic                  live_q;
    logic                  wren_q, wren_d;
    logic                  ack_q, ack_d;
    logic [31:0]           data_q, data_d;
    logic [2:0]            nbytes_q, nbytes_d;
    logic                  eof_q, eof_d;
    logic [31:0]           wcount_q, wcount_d;

    logic                    have_word;
    logic                    code_ready;
    logic [LEN_WIDTH-1:0]    len_eff;
    logic [MAX_CODE_LEN-1:0] frag;
    logic [ACC_WIDTH-1:0]    frag_shift;

    assign have_word  = (bit_cnt_q >= WORD_BITS);
    // live_q keeps code_ready low for the first cycle after reset release.
    assign code_ready = live_q && (state_q == StRun) && !have_word;

    always_comb begin
        len_eff = (bus.code_len > LEN_MAX) ? LEN_MAX : bus.code_len;
        frag    = '0;
        for (int i = 0; i < int'(MAX_CODE_LEN); i++) begin
            frag[i] = bus.code_data[i] && (i < int'(len_eff));
        end
        frag_shift = ACC_WIDTH'(frag) << bit_cnt_q;
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        bit_cnt_d = bit_cnt_q;
        wren_d    = 1'b0;
        ack_d     = 1'b0;
        data_d    = data_q;
        nbytes_d  = nbytes_q;
        eof_d     = eof_q;
        wcount_d  = wcount_q;

        unique case (state_q)
            StRun, StDrain: begin
                if (have_word) begin
                    if (!bus.out_full) begin
                        wren_d    = 1'b1;
                        data_d    = acc_q[31:0];
                        nbytes_d  = 3'd4;
                        eof_d     = 1'b0;
                        acc_d     = acc_q >> 32;
                        bit_cnt_d = bit_cnt_q - WORD_BITS;
                        wcount_d  = wcount_q + 32'd1;
                    end
                end else if (state_q == StDrain) begin
                    if (!bus.out_full) begin
                        // bit_cnt is byte-aligned and below 32 here.
                        wren_d    = 1'b1;
                        data_d    = acc_q[31:0];
                        nbytes_d  = 3'(bit_cnt_q[CNT_W-1:3]);
                        eof_d     = 1'b1;
                        wcount_d  = wcount_q + 32'd1;
                        acc_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = StDone;
                    end
                end else if (bus.code_valid && code_ready) begin
                    acc_d     = acc_q | frag_shift;
                    bit_cnt_d = bit_cnt_q + CNT_W'(len_eff);
                end else if (!bus.code_valid && bus.flush && live_q) begin
                    ack_d   = 1'b1;
                    state_d = StPad;
                end
            end
            StPad: begin
                bit_cnt_d = (bit_cnt_q + BYTE_PAD) & ~BYTE_PAD;
                state_d   = StDrain;
            end
            StDone: begin
                if (!bus.flush) begin
                    acc_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge core_clock) begin
        if (!rst_n) begin
            state_q   <= StRun;
            acc_q     <= '0;
            bit_cnt_q <= '0;
            live_q    <= 1'b0;
            wren_q    <= 1'b0;
            ack_q     <= 1'b0;
            data_q    <= '0;
            nbytes_q  <= '0;
            eof_q     <= 1'b0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            bit_cnt_q <= bit_cnt_d;
            live_q    <= 1'b1;
            wren_q    <= wren_d;
            ack_q     <= ack_d;
            data_q    <= data_d;
            nbytes_q  <= nbytes_d;
            eof_q     <= eof_d;
            wcount_q  <= wcount_d;
        end
    end

    assign bus.code_ready = code_ready;
    assign bus.flush_ack  = ack_q;
    assign bus.out_wren   = wren_q;
    assign bus.out_data   = data_q;
    assign bus.out_nbytes = nbytes_q;
    assign bus.out_eof    = eof_q;
    assign bus.word_count = wcount_q;
endmodule

// File: tb/tb_huff_bit_packer.sv
// Directed bench for huff_bit_packer: expected words go into a queue at stimulus
// time and a monitor compares every out_wren against the head of that queue.
module tb_huff_bit_packer;
    logic core_clock = 1'b0;
    logic rst_n      = 1'b0;
    int   checks     = 0;
    int   errors     = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  nbytes;
        logic        eof;
    } exp_t;
    exp_t exp_q[$];

    huff_bit_packer_if #(.MAX_CODE_LEN(25), .LEN_WIDTH(5)) bus ();

    huff_bit_packer #(.MAX_CODE_LEN(25), .LEN_WIDTH(5), .ACC_WIDTH(64)) dut (
        .core_clock(core_clock),
        .rst_n     (rst_n),
        .bus       (bus)
    );

    always #5 core_clock = ~core_clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge core_clock) begin
        if (rst_n && bus.out_wren) begin
            if (exp_q.size() == 0) begin
                check("unexpected_write", {bus.out_data, bus.out_nbytes, bus.out_eof}, 64'h0);
                if ({bus.out_data, bus.out_nbytes, bus.out_eof} == '0) begin
                    errors++;
                    $display("FAIL unexpected_write actual=wren required=no_write");
                end
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("out_word", {bus.out_data, bus.out_nbytes, bus.out_eof}, 64'(e));
            end
        end
    end

    task automatic tick();
        @(posedge core_clock);
        #1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [2:0] n, input logic eof);
        exp_t e;
        e.data   = d;
        e.nbytes = n;
        e.eof    = eof;
        exp_q.push_back(e);
    endtask

    task automatic check_all_zero(input string name);
        check(name, {bus.out_wren, bus.flush_ack, bus.out_eof, bus.out_nbytes, bus.code_ready},
              64'h0);
        check({name, "_data"}, {bus.out_data, bus.word_count}, 64'h0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        check_all_zero("reset_outputs");
        rst_n = 1'b1;
        check("ready_low_at_release", 64'(bus.code_ready), 64'h0);
        tick();
        check("ready_after_reset", 64'(bus.code_ready), 64'h1);
    endtask

    task automatic send(input logic [24:0] d, input logic [4:0] len);
        bit done = 1'b0;
        bus.code_data  = d;
        bus.code_len   = len;
        bus.code_valid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            if (bus.code_ready) done = 1'b1;
            tick();
        end
        bus.code_valid = 1'b0;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout actual=no_ready required=ready");
        end
    endtask

    task automatic do_flush();
        bit got = 1'b0;
        bus.flush = 1'b1;
        for (int i = 0; i < 200 && !got; i++) begin
            tick();
            if (bus.flush_ack) got = 1'b1;
        end
        bus.flush = 1'b0;
        check("flush_ack_seen", 64'(got), 64'h1);
        tick();
        check("flush_ack_pulse", 64'(bus.flush_ack), 64'h0);
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("queue_drained", 64'(exp_q.size()), 64'h0);
        tick();
        tick();
    endtask

    initial begin
        int bad;
        bus.code_data  = '0;
        bus.code_len   = '0;
        bus.code_valid = 1'b0;
        bus.flush      = 1'b0;
        bus.out_full   = 1'b0;
        #2;
        do_reset();

        // Four bytes back-to-back fill exactly one word.
        expect_word(32'h44332211, 3'd4, 1'b0);
        send(25'h11, 5'd8);
        send(25'h22, 5'd8);
        send(25'h33, 5'd8);
        send(25'h44, 5'd8);
        check("ready_low_full_word", 64'(bus.code_ready), 64'h0);
        tick();
        check("wren_after_fill", 64'(bus.out_wren), 64'h1);
        check("ready_back", 64'(bus.code_ready), 64'h1);
        check("word_count_1", 64'(bus.word_count), 64'h1);
        wait_drain();

        // Two 25-bit fragments: 50 bits, one word plus 18 residual zero bits.
        expect_word(32'h02000001, 3'd4, 1'b0);
        expect_word(32'h00000000, 3'd3, 1'b1);
        send(25'h0000001, 5'd25);
        send(25'h0000001, 5'd25);
        do_flush();
        wait_drain();
        check("word_count_3", 64'(bus.word_count), 64'h3);

        // 3-bit fragment with junk above code_len, then flush.
        expect_word(32'h00000005, 3'd1, 1'b1);
        send(25'h1FFFFFD, 5'd3);
        do_flush();
        wait_drain();
        check("ready_after_done", 64'(bus.code_ready), 64'h1);

        // Flush of an empty stream straight after reset.
        do_reset();
        expect_word(32'h0, 3'd0, 1'b1);
        do_flush();
        wait_drain();
        check("word_count_empty_flush", 64'(bus.word_count), 64'h1);

        // 40 bits under backpressure.
        bus.out_full = 1'b1;
        send(25'hABCDE, 5'd20);
        send(25'h12345, 5'd20);
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (bus.out_wren || bus.code_ready) bad++;
            tick();
        end
        check("backpressure_hold", 64'(bad), 64'h0);
        expect_word(32'h345ABCDE, 3'd4, 1'b0);
        bus.out_full = 1'b0;
        wait_drain();
        expect_word(32'h00000012, 3'd1, 1'b1);
        do_flush();
        wait_drain();

        // Reset while stuck in DRAIN with bits pending.
        bus.out_full = 1'b1;
        send(25'hAAAAAA, 5'd24);
        do_flush();
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        check_all_zero("mid_drain_reset");
        rst_n = 1'b1;
        tick();
        bus.out_full = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        expect_word(32'h0000005A, 3'd1, 1'b1);
        send(25'h5A, 5'd8);
        do_flush();
        wait_drain();
        check("word_count_after_reset", 64'(bus.word_count), 64'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
